timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shares one interval timer among NUM_REQ requesters. Each requester asks for a delay of R clock cycles. The block grants the timer to one requester at a time using round-robin arbitration, loads that requester's rollover value, and counts 1..R with the team's flex-counter semantics. When the count completes it pulses a per-requester done. It sits between protocol FSMs (UART bit timing, debounce, wait states) and the shared counting resource.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- CNT_BITS, 4: width of each rollover value and of the count
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  request per requester; level, held until done or cancel
- req_val  in  NUM_REQ*CNT_BITS  rollover value; requester i uses bits [i*CNT_BITS +: CNT_BITS]
- abort  in  1  synchronous global cancel of the active job
- grant  out  NUM_REQ  one-hot owner of the timer; all-zero when idle
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- busy  out  1  high in any state except IDLE
- count_out  out  CNT_BITS  current timer count

## Operation
- States:
  - IDLE: grant=0, count=0.
  - LOAD: grant set, rollover latched, count=0.
  - RUN: count increments by 1 per cycle.
  - DONE: done[owner]=1 for this cycle only.
- IDLE→LOAD when req≠0. The winner is the first asserted req found scanning upward from (last_owner+1) mod NUM_REQ.
- LOAD→RUN when the latched R≠0. LOAD→DONE when R=0 (zero-length job; done still fires).
- RUN: count goes 1,2,…,R. RUN→DONE on the edge after count_out==R. Changes to req_val after LOAD are ignored.
- DONE→IDLE unconditionally. last_owner is updated to the owner.
- Cancel: if req[owner] drops in LOAD or RUN, the next state is IDLE. No done fires, and last_owner is still updated.
- abort=1 in LOAD or RUN gives the same result as a cancel. abort has no effect in IDLE or DONE.
- A cancel and a completion in the same cycle (req drop while count==R): the cancel wins and no done fires.
- Arithmetic is unsigned, CNT_BITS wide. R = 2^CNT_BITS−1 is legal and no overflow is possible.
- Reset values: state IDLE, grant=0, done=0, busy=0, count_out=0, last_owner=NUM_REQ−1 (requester 0 has top priority first).
- A reset in mid-job returns everything to reset values immediately (asynchronously). No done fires.

## Timing
- All outputs come straight from registers; there are no combinational input-to-output paths.
- Request seen in IDLE at edge N:
  - grant high from edge N+1 (LOAD).
  - count_out=1 at N+2.
  - count_out=R at N+1+R.
  - done pulse during N+2+R to N+3+R.
  - grant low from edge N+3+R.
- grant stays high for R+2 cycles, done cycle included. For R=0 it stays high 2 cycles.
- There is at least one IDLE cycle between consecutive grants. Back-to-back job throughput is R+3 cycles.
- The done pulse coincides with the final grant cycle.
- busy matches (grant≠0).

## Configuration
- TIMER_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest asserted index always wins and last_owner is not used.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then req=4'b0001, val0=3 → grant=0001 for 5 cycles; count_out shows 0,1,2,3; done=0001 for 1 cycle; busy falls with grant.
- req=4'b1111 held, all vals=1 → grants in order 0001, 0010, 0100, 1000, 0001, each followed by a done pulse. Under TIMER_ARB_FIXED_PRIO_EN → grant 0001 every time.
- req[2] only, val2=0 → grant=0100 for exactly 2 cycles, done[2] pulses, count_out stays 0.
- req[1], val1=15 → count_out reaches 15 and returns to 0 with no wrap glitch; done[1] fires once.
- req[3], val3=8, drop req[3] at count 4 → next cycle IDLE, no done. A separate run with abort at count 4 gives the same result.
- Assert n_rst=0 at count 5 of an R=10 job → all outputs 0 immediately. After release, req[0] is granted before req[3] when both are asserted.

Source files
------------

// File: rtl/timer_arbiter.sv
// Shared interval timer with round-robin arbitration among NUM_REQ requesters.
// Define TIMER_ARB_FIXED_PRIO_EN to switch to fixed lowest-index-wins priority.
module timer_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CNT_BITS = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_BITS-1:0]  req_val,
  input  logic                         abort,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [CNT_BITS-1:0]          count_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t              state, next_state;
  logic [IDX_W-1:0]    owner, last_owner, winner;
  logic [CNT_BITS-1:0] rollover, count, winner_val;
  logic                win_found;
  logic                cancel;
  int                  best_dist, cand_dist;

  assign cancel = abort || !req[owner];

  // Winner is the asserted request with the smallest distance from the scan start.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    winner     = '0;
    winner_val = '0;
    win_found  = 1'b0;
    best_dist  = NUM_REQ;
    cand_dist  = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
      cand_dist = j;
`else
      cand_dist = (j - int'(last_owner) - 1 + 2 * NUM_REQ) % NUM_REQ;
`endif
      if (req[j] && cand_dist < best_dist) begin
        best_dist  = cand_dist;
        winner     = IDX_W'(j);
        winner_val = req_val[j*CNT_BITS +: CNT_BITS];
        win_found  = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      owner      <= '0;
      rollover   <= '0;
      count      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= next_state;
      if (state == IDLE && win_found) begin
        owner    <= winner;
        rollover <= winner_val;
      end
      if (state != IDLE && next_state == IDLE)
        last_owner <= owner;
      case (next_state)
        RUN:     count <= count + CNT_BITS'(1);
        DONE:    count <= count;
        default: count <= '0;
      endcase
    end
  end

  // Next-state logic; a cancel always beats a completion in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (win_found) next_state = LOAD;
      LOAD: begin
        if (cancel)               next_state = IDLE;
        else if (rollover == '0)  next_state = DONE;
        else                      next_state = RUN;
      end
      RUN: begin
        if (cancel)                  next_state = IDLE;
        else if (count == rollover)  next_state = DONE;
        else                         next_state = RUN;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    grant = '0;
    done  = '0;
    busy  = 1'b0;
    if (state != IDLE) begin
      grant = NUM_REQ'(1) << owner;
      busy  = 1'b1;
    end
    if (state == DONE)
      done = NUM_REQ'(1) << owner;
  end

  assign count_out = count;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: directed scenarios plus random traffic
// compared against a job-age reference model.
module tb_timer_arbiter;

  localparam int NR = 4;
  localparam int CB = 4;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [NR-1:0]    req;
  logic [NR*CB-1:0] req_val;
  logic             abort;
  logic [NR-1:0]    grant, done;
  logic             busy;
  logic [CB-1:0]    count_out;
  logic [CB-1:0]    vals [NR];

  int total = 0;
  int bad   = 0;

  // Reference model: a job is described by owner, length R and its age since grant.
  bit            m_active;
  int            m_owner, m_r, m_age, m_last;
  logic [NR-1:0] e_grant, e_done;
  logic [CB-1:0] e_count;
  logic [NR-1:0] prev_grant;
  logic [NR-1:0] grant_q [$];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < NR; i++) req_val[i*CB +: CB] = vals[i];

  timer_arbiter #(.NUM_REQ(NR), .CNT_BITS(CB)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .req_val   (req_val),
    .abort     (abort),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .count_out (count_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
`ifdef TIMER_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (req[k]) return k;
`else
    int c;
    for (int k = 1; k <= NR; k++) begin
      c = (m_last + k) % NR;
      if (req[c]) return c;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_r      = 0;
    m_age    = 0;
    m_last   = NR - 1;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    if (!m_active) begin
      if (req != '0) begin
        m_owner  = pick();
        m_r      = int'(vals[m_owner]);
        m_age    = 0;
        m_active = 1'b1;
      end
    end else if (m_age == m_r + 1) begin
      m_active = 1'b0;
      m_last   = m_owner;
    end else if (abort || !req[m_owner]) begin
      m_active = 1'b0;
      m_last   = m_owner;
    end else begin
      m_age++;
    end
    e_grant = m_active ? NR'(1) << m_owner : '0;
    e_done  = (m_active && m_age == m_r + 1) ? NR'(1) << m_owner : '0;
    e_count = m_active ? CB'((m_age < m_r) ? m_age : m_r) : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("grant", grant, e_grant);
    check("done", done, e_done);
    check("busy", busy, m_active);
    check("count", count_out, e_count);
    if (grant != '0 && prev_grant == '0) grant_q.push_back(grant);
    prev_grant = grant;
  endtask

  // Asynchronous reset pulse applied between edges; outputs must clear at once.
  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count_out, 0);
    #1;
    n_rst = 1'b1;
    model_reset();
    prev_grant = '0;
  endtask

  task automatic idle_ticks(input int n);
    req   = '0;
    abort = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [NR-1:0] exp_order [5];

  initial begin
    n_rst = 1'b1;
    req   = '0;
    abort = 1'b0;
    for (int i = 0; i < NR; i++) vals[i] = '0;
    model_reset();
    prev_grant = '0;
    #1;
    do_reset();
    idle_ticks(2);

    // Single job, R=3.
    vals[0] = 4'd3;
    req     = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    idle_ticks(2);

    // Round-robin rotation from a fresh reset, all requesters with R=1.
    do_reset();
    grant_q.delete();
    for (int i = 0; i < NR; i++) vals[i] = 4'd1;
    req = 4'b1111;
    for (int i = 0; i < 20; i++) tick();
    idle_ticks(2);
`ifdef TIMER_ARB_FIXED_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    check("rr_njobs", grant_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order%0d", i), (i < grant_q.size()) ? grant_q[i] : '0, exp_order[i]);

    // Zero-length job.
    vals[2] = 4'd0;
    req     = 4'b0100;
    for (int i = 0; i < 2; i++) tick();
    idle_ticks(2);

    // Maximum-length job.
    vals[1] = 4'd15;
    req     = 4'b0010;
    for (int i = 0; i < 17; i++) tick();
    idle_ticks(2);

    // Cancel by dropping req at count 4, then abort at count 4.
    vals[3] = 4'd8;
    req     = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    check("cancel_at4", count_out, 4);
    req = 4'b0000;
    tick();
    idle_ticks(1);
    req = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    req   = 4'b0000;
    idle_ticks(1);

    // Reset mid-job, then requesters 0 and 3 together.
    vals[0] = 4'd10;
    req     = 4'b0001;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_count", count_out, 5);
    do_reset();
    grant_q.delete();
    vals[0] = 4'd2;
    vals[3] = 4'd2;
    req     = 4'b1001;
    for (int i = 0; i < 12; i++) tick();
    idle_ticks(2);
    check("post_rst_first", (grant_q.size() > 0) ? grant_q[0] : '0, 4'b0001);
`ifdef TIMER_ARB_FIXED_PRIO_EN
    check("post_rst_second", (grant_q.size() > 1) ? grant_q[1] : '0, 4'b0001);
`else
    check("post_rst_second", (grant_q.size() > 1) ? grant_q[1] : '0, 4'b1000);
`endif

    // Random traffic with cancels, aborts and late req_val changes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]  = 1'b1;
          vals[i] = ($urandom_range(0, 7) == 0) ? 4'hF : CB'($urandom_range(0, 5));
        end else if (req[i] && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          vals[i] = CB'($urandom);
        end
      end
      if (e_done != '0 && $urandom_range(0, 1) == 0) req[m_owner] = 1'b0;
      abort = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_ticks(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
